// File: rtl/sd_server_pkg.sv
// sd_server_pkg
// Shared definitions for the sector server: transfer state encoding,
// sector geometry and a small helper for detecting the final word of a
// sector.
package sd_server_pkg;

    localparam int unsigned SECTOR_WORDS = 256;
    localparam int unsigned WORD_IDX_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_CAP,
        WR_MEM,
        DONE
    } state_t;

    function automatic logic is_last_word(input logic [WORD_IDX_W-1:0] idx);
        return idx == WORD_IDX_W'(SECTOR_WORDS - 1);
    endfunction

endpackage

// File: rtl/sd_sector_server.sv
// sd_sector_server
// Responder side of the sd_lba/sd_rd/sd_wr/sd_ack sector handshake. Each
// accepted request moves one 512-byte sector (256 x 16-bit words) between
// the initiator's buffer and a word-addressed backing store reached over a
// ready-handshake memory port.
//
// Ports
//   clk_sys       system clock, rising edge
//   reset         asynchronous, active-high
//   sd_lba        sector number, sampled on acceptance
//   sd_rd/sd_wr   read / write request levels (read wins if both)
//   sd_ack        high for the whole transfer
//   sd_buff_addr  word index within the sector
//   sd_buff_dout  read data towards the initiator buffer
//   sd_buff_wr    one-cycle strobe qualifying sd_buff_dout/sd_buff_addr
//   sd_buff_din   initiator buffer data, one cycle after sd_buff_addr
//   mem_addr      {lba[LBA_BITS-1:0], word index}
//   mem_rd/mem_wr memory request, held until mem_ready
//   mem_wdata     memory write data
//   mem_rdata     memory read data, valid with mem_ready
//   mem_ready     completes the pending memory request
//   err           sticky out-of-range flag of the current/last request
module sd_sector_server
    import sd_server_pkg::*;
#(
    parameter int unsigned LBA_BITS = 6
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_din,
    output logic [LBA_BITS+7:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  err
);

    state_t                  state;
    logic [WORD_IDX_W-1:0]   idx;
    logic [WORD_IDX_W-1:0]   idx_next;
    logic [LBA_BITS-1:0]     lba_q;
    logic                    oor;
    logic                    req_oor;

    assign idx_next = idx + WORD_IDX_W'(1);

    // Any set bit above the backed address range makes the request
    // out of range.
    assign req_oor = |(sd_lba >> LBA_BITS);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            lba_q        <= '0;
            oor          <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            err          <= 1'b0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (sd_rd || sd_wr) begin
                        lba_q        <= sd_lba[LBA_BITS-1:0];
                        oor          <= req_oor;
                        err          <= req_oor;
                        idx          <= '0;
                        sd_ack       <= 1'b1;
                        sd_buff_addr <= '0;
                        mem_addr     <= {sd_lba[LBA_BITS-1:0], 8'h00};
                        if (sd_rd) begin
                            // Out-of-range reads never touch memory.
                            mem_rd <= ~req_oor;
                            state  <= RD_REQ;
                        end else begin
                            state  <= WR_ADDR;
                        end
                    end
                end

                RD_REQ: begin
                    if (oor || mem_ready) begin
                        sd_buff_dout <= oor ? 16'h0000 : mem_rdata;
                        mem_rd       <= 1'b0;
                        state        <= RD_PUT;
                    end
                end

                // The strobe is registered here, so it is visible in the
                // cycle after RD_PUT (overlapping the next RD_REQ, or DONE
                // for the last word) while dout/addr are still stable.
                RD_PUT: begin
                    sd_buff_wr   <= 1'b1;
                    sd_buff_addr <= idx;
                    if (is_last_word(idx)) begin
                        state <= DONE;
                    end else begin
                        idx      <= idx_next;
                        mem_addr <= {lba_q, idx_next};
                        mem_rd   <= ~oor;
                        state    <= RD_REQ;
                    end
                end

                // sd_buff_addr already holds the index; the initiator's
                // buffer answers one cycle later.
                WR_ADDR: begin
                    state <= WR_CAP;
                end

                WR_CAP: begin
                    mem_wdata <= sd_buff_din;
                    mem_wr    <= ~oor;
                    state     <= WR_MEM;
                end

                WR_MEM: begin
                    if (oor || mem_ready) begin
                        mem_wr <= 1'b0;
                        if (is_last_word(idx)) begin
                            state <= DONE;
                        end else begin
                            idx          <= idx_next;
                            sd_buff_addr <= idx_next;
                            mem_addr     <= {lba_q, idx_next};
                            state        <= WR_ADDR;
                        end
                    end
                end

                DONE: begin
                    sd_ack <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_server.sv
// tb_sd_sector_server
// Directed bench for sd_sector_server: drives sector requests like the
// save/load initiator, models a word store and a registered initiator
// buffer, and checks transfers against values computed from the request.
module tb_sd_sector_server;

    logic        clk;
    logic        reset;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    sd_sector_server #(.LBA_BITS(6)) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing store and initiator buffer
    logic [15:0] store [0:16383];
    logic [15:0] ibuf  [0:255];
    logic        rand_ready;

    assign mem_rdata = store[mem_addr];

    initial begin
        for (int i = 0; i < 16384; i++) store[i] = 16'(i) ^ 16'hA5A5;
        forever begin
            @(posedge clk);
            if (mem_wr && mem_ready) store[mem_addr] = mem_wdata;
        end
    end

    always @(posedge clk) sd_buff_din <= ibuf[sd_buff_addr];

    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor state, sampled on the falling edge
    int          cyc = 0;
    int          ack_cnt, strobe_cnt, strobe_bad, first_off;
    int          rd_hs, wr_hs, wr_bad, both_cnt, hold_bad, wait_cnt;
    int          rise_cyc = 0, fall_cyc = -1, min_gap = 1000000;
    logic        ack_prev = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0, rdy_prev = 1'b1;
    logic [31:0] exp_lba;
    logic        exp_oor;
    logic [15:0] exp_word;
    logic [13:0] exp_addr;

    always @(negedge clk) begin
        cyc++;
        if (sd_ack && !ack_prev) begin
            rise_cyc = cyc;
            if (fall_cyc >= 0 && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
        end
        if (!sd_ack && ack_prev) fall_cyc = cyc;
        if (sd_ack) ack_cnt++;
        if (sd_buff_wr) begin
            if (first_off < 0) first_off = cyc - rise_cyc;
            exp_word = exp_oor ? 16'h0000
                               : ({2'b00, exp_lba[5:0], 8'(strobe_cnt)} ^ 16'hA5A5);
            if (sd_buff_addr !== 8'(strobe_cnt) || sd_buff_dout !== exp_word) strobe_bad++;
            strobe_cnt++;
        end
        if (mem_rd && mem_wr) both_cnt++;
        if (mem_rd && !mem_ready) wait_cnt++;
        if (mem_rd && mem_ready) rd_hs++;
        if (mem_wr && mem_ready) begin
            exp_addr = {exp_lba[5:0], 8'(wr_hs)};
            if (mem_addr !== exp_addr || mem_wdata !== 16'h1000 + 16'(wr_hs)) wr_bad++;
            wr_hs++;
        end
        if ((rd_prev && !rdy_prev && !mem_rd) || (wr_prev && !rdy_prev && !mem_wr)) hold_bad++;
        ack_prev = sd_ack;
        rd_prev  = mem_rd;
        wr_prev  = mem_wr;
        rdy_prev = mem_ready;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        ack_cnt = 0; strobe_cnt = 0; strobe_bad = 0; first_off = -1;
        rd_hs = 0; wr_hs = 0; wr_bad = 0; both_cnt = 0; hold_bad = 0; wait_cnt = 0;
    endtask

    task automatic wait_level(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (sd_ack === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where ack is low.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] lba, output bit ok);
        bit ok1, ok2;
        clear_counts();
        exp_lba = lba;
        exp_oor = (lba[31:6] != 26'd0);
        sd_lba  = lba;
        sd_rd   = rd;
        sd_wr   = wr;
        wait_level(1'b1, ok1);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_level(1'b0, ok2);
        ok = ok1 && ok2;
    endtask

    function automatic logic [63:0] out_vec();
        return {5'd0, sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout,
                mem_rd, mem_wr, mem_addr, mem_wdata, err};
    endfunction

    initial begin
        bit ok;
        bit found;
        int total_cnt, total_bad, bad;

        reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; rand_ready = 1'b0;
        exp_lba = '0; exp_oor = 1'b0;
        for (int i = 0; i < 256; i++) ibuf[i] = 16'h1000 + 16'(i);
        clear_counts();

        repeat (2) @(negedge clk);
        chk("reset_outputs", out_vec(), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read of LBA 3
        xfer(1'b1, 1'b0, 32'd3, ok);
        chk("rd3_handshake", 64'(ok), 64'd1);
        chk("rd3_strobes", 64'(strobe_cnt), 64'd256);
        chk("rd3_data", 64'(strobe_bad), 64'd0);
        chk("rd3_ack_cycles", 64'(ack_cnt), 64'd513);
        chk("rd3_first_strobe", 64'(first_off), 64'd2);
        chk("rd3_mem_reads", 64'(rd_hs), 64'd256);
        chk("rd3_err", 64'(err), 64'd0);

        // Read of LBA 2 with random memory waits
        rand_ready = 1'b1;
        xfer(1'b1, 1'b0, 32'd2, ok);
        rand_ready = 1'b0;
        chk("rd2w_handshake", 64'(ok), 64'd1);
        chk("rd2w_strobes", 64'(strobe_cnt), 64'd256);
        chk("rd2w_data", 64'(strobe_bad), 64'd0);
        chk("rd2w_waits_seen", 64'(wait_cnt != 0), 64'd1);
        chk("rd2w_ack_cycles", 64'(ack_cnt), 64'(513 + wait_cnt));
        chk("rd2w_hold", 64'(hold_bad), 64'd0);
        chk("rd2w_rd_wr_overlap", 64'(both_cnt), 64'd0);

        // Out-of-range read
        xfer(1'b1, 1'b0, 32'd64, ok);
        chk("oor_handshake", 64'(ok), 64'd1);
        chk("oor_strobes", 64'(strobe_cnt), 64'd256);
        chk("oor_zero_data", 64'(strobe_bad), 64'd0);
        chk("oor_no_mem_rd", 64'(rd_hs + wait_cnt), 64'd0);
        chk("oor_ack_cycles", 64'(ack_cnt), 64'd513);
        chk("oor_err", 64'(err), 64'd1);

        // Read and write together at LBA 1: read wins, clears err
        xfer(1'b1, 1'b1, 32'd1, ok);
        chk("both_handshake", 64'(ok), 64'd1);
        chk("both_data", 64'(strobe_bad), 64'd0);
        chk("both_strobes", 64'(strobe_cnt), 64'd256);
        chk("both_no_mem_wr", 64'(wr_hs), 64'd0);
        chk("both_err_cleared", 64'(err), 64'd0);

        // 16 back-to-back reads, each raised as the previous ack falls
        total_cnt = 0; total_bad = 0; bad = 0; min_gap = 1000000;
        for (int l = 0; l < 16; l++) begin
            xfer(1'b1, 1'b0, 32'(l), ok);
            if (!ok) bad++;
            total_cnt += strobe_cnt;
            total_bad += strobe_bad;
        end
        chk("seq_handshakes", 64'(bad), 64'd0);
        chk("seq_words", 64'(total_cnt), 64'd4096);
        chk("seq_data", 64'(total_bad), 64'd0);
        chk("seq_idle_gap", 64'(min_gap >= 1), 64'd1);

        // Write LBA 5 from the initiator buffer
        xfer(1'b0, 1'b1, 32'd5, ok);
        chk("wr5_handshake", 64'(ok), 64'd1);
        chk("wr5_ack_cycles", 64'(ack_cnt), 64'd769);
        chk("wr5_mem_writes", 64'(wr_hs), 64'd256);
        chk("wr5_addr_data", 64'(wr_bad), 64'd0);
        chk("wr5_no_mem_rd", 64'(rd_hs), 64'd0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (store[{6'd5, 8'(i)}] !== 16'h1000 + 16'(i)) bad++;
        chk("wr5_store", 64'(bad), 64'd0);

        // Reset in the middle of a write to LBA 6
        clear_counts();
        exp_lba = 32'd6; exp_oor = 1'b0;
        sd_lba = 32'd6; sd_wr = 1'b1;
        wait_level(1'b1, ok);
        sd_wr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mem_wr && mem_addr[7:0] == 8'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_word100", 64'(found && ok), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", out_vec(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_word99_written", 64'(store[14'h663]), 64'h1063);
        chk("rst_word100_dropped", 64'(store[14'h664]), 64'(16'h0664 ^ 16'hA5A5));
        @(negedge clk);

        // Fresh read after the aborted write starts again at word 0
        xfer(1'b1, 1'b0, 32'd3, ok);
        chk("post_rst_handshake", 64'(ok), 64'd1);
        chk("post_rst_strobes", 64'(strobe_cnt), 64'd256);
        chk("post_rst_data", 64'(strobe_bad), 64'd0);
        chk("post_rst_first_strobe", 64'(first_off), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
